// File: rtl/axi_stream_demux_1x2_if.sv
// Handshake bundle for the 1:2 stream demux: one upstream source, two downstream sinks.
// The slave modport is the demux view; the master modport drives it.
interface axi_stream_demux_1x2_if #(
    parameter int width = 31
);
    logic [width:0] in_data;
    logic           in_last;
    logic           in_valid;
    logic           in_ready;
    logic           sel;
    logic [width:0] out1_data;
    logic           out1_last;
    logic           out1_valid;
    logic           out1_ready;
    logic [width:0] out2_data;
    logic           out2_last;
    logic           out2_valid;
    logic           out2_ready;
    logic           busy;

    modport slave (
        input  in_data, in_last, in_valid, sel, out1_ready, out2_ready,
        output in_ready, out1_data, out1_last, out1_valid,
               out2_data, out2_last, out2_valid, busy
    );

    modport master (
        output in_data, in_last, in_valid, sel, out1_ready, out2_ready,
        input  in_ready, out1_data, out1_last, out1_valid,
               out2_data, out2_last, out2_valid, busy
    );
endinterface

// File: rtl/axi_stream_demux_1x2.sv
// 1:2 valid/ready demux with a single registered output stage and a per-burst route lock.
// The route is sampled from sel on a burst's first beat and held until its last beat is taken.
module axi_stream_demux_1x2 #(
    parameter int width = 31
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    axi_stream_demux_1x2_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           route_q;
    logic           vld_p0;
    logic [width:0] data_p0;
    logic           last_p0;
    logic           dest_p0;

    logic           push;
    logic           pop;
    logic           sel_ready;
    logic           beat_dest;
    logic           in_ready_w;

    // The latched route only steers continuation beats; a new burst takes sel directly.
    assign beat_dest  = (state_q == IDLE) ? bus.sel : route_q;
    assign sel_ready  = dest_p0 ? bus.out2_ready : bus.out1_ready;
    assign pop        = vld_p0 && sel_ready;
    assign in_ready_w = ARESETN && (!vld_p0 || pop);
    assign push       = bus.in_valid && in_ready_w;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push && !bus.in_last) state_d = LOCKED;
            LOCKED:  if (push &&  bus.in_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            route_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push && state_q == IDLE) route_q <= bus.sel;
        end
    end

    // Stage p0: output buffer; a same-cycle pop and push leaves it full with the new beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            vld_p0  <= 1'b0;
            dest_p0 <= 1'b0;
        end else if (push) begin
            vld_p0  <= 1'b1;
            dest_p0 <= beat_dest;
        end else if (pop) begin
            vld_p0  <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            data_p0 <= bus.in_data;
            last_p0 <= bus.in_last;
        end
    end

    // Payload is gated by the per-output valid so an idle or unselected output reads as zero.
    always_comb begin
        bus.out1_valid = vld_p0 && !dest_p0;
        bus.out2_valid = vld_p0 &&  dest_p0;
        bus.out1_data  = bus.out1_valid ? data_p0 : '0;
        bus.out1_last  = bus.out1_valid ? last_p0 : 1'b0;
        bus.out2_data  = bus.out2_valid ? data_p0 : '0;
        bus.out2_last  = bus.out2_valid ? last_p0 : 1'b0;
        bus.in_ready   = in_ready_w;
        bus.busy       = (state_q == LOCKED);
    end

endmodule

// File: tb/tb_axi_stream_demux_1x2.sv
// Directed bench for the 1:2 stream demux: reset, single beat, burst lock,
// backpressure, back-to-back bursts and reset mid-burst.
module tb_axi_stream_demux_1x2;

    logic ACLK;
    logic ARESETN;
    int   compared;
    int   mismatched;

    axi_stream_demux_1x2_if #(.width(31)) bus ();

    axi_stream_demux_1x2 #(.width(31)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input logic s, input logic [31:0] d, input logic l, input logic v);
        bus.sel      = s;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = v;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        ARESETN    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;

        // Reset held with in_valid asserted
        repeat (3) tick();
        chk("rst_in_ready",   {31'd0, bus.in_ready},   32'd0);
        chk("rst_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        chk("rst_out2_valid", {31'd0, bus.out2_valid}, 32'd0);
        chk("rst_busy",       {31'd0, bus.busy},       32'd0);
        chk("rst_out1_data",  bus.out1_data,           32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        ARESETN = 1'b1;
        #1;
        chk("rel_in_ready",   {31'd0, bus.in_ready},   32'd1);

        // Single beat to out2
        tick();
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        drive(1'b1, 32'hA5A5A5A5, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("sb_out2_valid", {31'd0, bus.out2_valid}, 32'd1);
        chk("sb_out2_data",  bus.out2_data,           32'hA5A5A5A5);
        chk("sb_out2_last",  {31'd0, bus.out2_last},  32'd1);
        chk("sb_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        chk("sb_out1_data",  bus.out1_data,           32'd0);
        chk("sb_busy",       {31'd0, bus.busy},       32'd0);
        tick();
        chk("sb_drain",      {31'd0, bus.out2_valid}, 32'd0);

        // Burst lock: sel changes after beat 0 are ignored
        drive(1'b0, 32'h11111111, 1'b0, 1'b1);
        tick();
        chk("bl_b0_data",  bus.out1_data,           32'h11111111);
        chk("bl_b0_busy",  {31'd0, bus.busy},       32'd1);
        drive(1'b1, 32'h22222222, 1'b0, 1'b1);
        tick();
        chk("bl_b1_data",  bus.out1_data,           32'h22222222);
        chk("bl_b1_o2v",   {31'd0, bus.out2_valid}, 32'd0);
        chk("bl_b1_busy",  {31'd0, bus.busy},       32'd1);
        drive(1'b1, 32'h33333333, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bl_b2_data",  bus.out1_data,           32'h33333333);
        chk("bl_b2_last",  {31'd0, bus.out1_last},  32'd1);
        chk("bl_b2_o2v",   {31'd0, bus.out2_valid}, 32'd0);
        chk("bl_b2_busy",  {31'd0, bus.busy},       32'd0);
        tick();
        chk("bl_drain",    {31'd0, bus.out1_valid}, 32'd0);

        // Backpressure mid-burst on out1
        drive(1'b0, 32'h44444444, 1'b0, 1'b1);
        tick();
        bus.out1_ready = 1'b0;
        drive(1'b1, 32'h55555555, 1'b0, 1'b1);
        #1;
        chk("bp_in_ready0", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data",  bus.out1_data,           32'h44444444);
            chk("bp_hold_valid", {31'd0, bus.out1_valid}, 32'd1);
            chk("bp_hold_ready", {31'd0, bus.in_ready},   32'd0);
        end
        bus.out1_ready = 1'b1;
        #1;
        chk("bp_in_ready1", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("bp_resume_55", bus.out1_data, 32'h55555555);
        drive(1'b1, 32'h66666666, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bp_resume_66", bus.out1_data,          32'h66666666);
        chk("bp_last",      {31'd0, bus.out1_last}, 32'd1);
        chk("bp_busy",      {31'd0, bus.busy},      32'd0);
        tick();
        chk("bp_drain",     {31'd0, bus.out1_valid}, 32'd0);

        // Back-to-back bursts with no bubble between them
        drive(1'b0, 32'h00000081, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h00000082, 1'b1, 1'b1);
        tick();
        chk("bb_o1_82", bus.out1_data, 32'h00000082);
        drive(1'b1, 32'h00000091, 1'b0, 1'b1);
        tick();
        chk("bb_o2v",     {31'd0, bus.out2_valid}, 32'd1);
        chk("bb_o2_91",   bus.out2_data,           32'h00000091);
        chk("bb_o1v",     {31'd0, bus.out1_valid}, 32'd0);
        chk("bb_busy",    {31'd0, bus.busy},       32'd1);
        drive(1'b0, 32'h00000092, 1'b1, 1'b1);
        tick();
        chk("bb_o2_92",   bus.out2_data,           32'h00000092);
        chk("bb_busy0",   {31'd0, bus.busy},       32'd0);

        // Reset mid-burst while locked and full
        drive(1'b0, 32'h000000A1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rm_pre_data", bus.out1_data,      32'h000000A1);
        chk("rm_pre_busy", {31'd0, bus.busy},  32'd1);
        ARESETN = 1'b0;
        #1;
        chk("rm_o1v",      {31'd0, bus.out1_valid}, 32'd0);
        chk("rm_o1d",      bus.out1_data,           32'd0);
        chk("rm_busy",     {31'd0, bus.busy},       32'd0);
        chk("rm_in_ready", {31'd0, bus.in_ready},   32'd0);
        tick();
        ARESETN = 1'b1;
        drive(1'b1, 32'h000000B1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rm_new_o2v",  {31'd0, bus.out2_valid}, 32'd1);
        chk("rm_new_o2d",  bus.out2_data,           32'h000000B1);
        chk("rm_new_o1v",  {31'd0, bus.out1_valid}, 32'd0);
        chk("rm_new_busy", {31'd0, bus.busy},       32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
